// File: rtl/mps_multicycle_core.sv
// mps_multicycle_core: multi-cycle MPS core, req/ack instruction and data buses; define MPS_BRANCH_EN to build BEQZ
module mps_multicycle_core #(
  parameter int DATA_WIDTH = 16,
  parameter int IADDR_WIDTH = 8,
  parameter int DADDR_WIDTH = 8,
  parameter int REG_COUNT = 16
) (
  input  logic                   clock,
  input  logic                   nreset,
  output logic                   imem_req,
  output logic [IADDR_WIDTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [15:0]            imem_value,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]  dmem_wvalue,
  input  logic                   dmem_ack,
  input  logic [DATA_WIDTH-1:0]  dmem_rvalue,
  output logic                   retired,
  output logic                   halted
);
  localparam int SW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  state_t state;
  logic [IADDR_WIDTH-1:0] pc, pc_inc, pc_next;
  logic [15:0] ir;
  logic [DATA_WIDTH-1:0] regs [16];
  logic [3:0] op;
  logic [DATA_WIDTH-1:0] va, vb, imm, exec_val, wb_val;
  logic [SW-1:0] sh;
  logic is_mem, wb_en;
  // r0 and unimplemented indices always read as zero
  function automatic logic [DATA_WIDTH-1:0] rd_reg(input logic [3:0] i);
    return (i == 4'd0 || int'(i) >= REG_COUNT) ? '0 : regs[i];
  endfunction
  assign op = ir[15:12];
  assign va = rd_reg(ir[7:4]);
  assign vb = rd_reg(ir[3:0]);
  assign sh = vb[SW-1:0];
  assign imm = DATA_WIDTH'(signed'(ir[7:0]));
  assign pc_inc = pc + 1'b1;
`ifdef MPS_BRANCH_EN
  logic [DATA_WIDTH-1:0] vd;
  assign vd = rd_reg(ir[11:8]);
  assign pc_next = (op == 4'hB && vd == '0) ? pc_inc + IADDR_WIDTH'(signed'(ir[7:0])) : pc_inc;
`else
  assign pc_next = pc_inc;
`endif
  assign is_mem = op == 4'h9 || op == 4'hA;
  assign wb_en = (state == S_EXEC && op >= 4'h1 && op <= 4'h8) || (state == S_MEM && dmem_ack && op == 4'h9);
  assign wb_val = state == S_MEM ? dmem_rvalue : exec_val;
  assign imem_req = state == S_FETCH;
  assign imem_addr = pc;
  assign dmem_req = state == S_MEM;
  assign dmem_we = dmem_req && op == 4'hA;
  assign dmem_addr = DADDR_WIDTH'(va);
  assign dmem_wvalue = vb;
  assign retired = (state == S_EXEC && !is_mem) || (state == S_MEM && dmem_ack);
  assign halted = state == S_HALT;
  // ALU result for register-writing EXEC opcodes; carries and overflow discarded
  always_comb begin
    exec_val = '0;
    case (op)
      4'h1: exec_val = va + vb;
      4'h2: exec_val = va - vb;
      4'h3: exec_val = va & vb;
      4'h4: exec_val = va | vb;
      4'h5: exec_val = va ^ vb;
      4'h6: exec_val = va << sh;
      4'h7: exec_val = va >> sh;
      4'h8: exec_val = imm;
      default: exec_val = '0;
    endcase
  end
  // sequencer: BOOT -> FETCH -> EXEC -> (MEM ->) FETCH, HALT terminal
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      state <= S_BOOT;
      pc <= '0;
      ir <= '0;
    end else begin
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: if (imem_ack) begin
          ir <= imem_value;
          state <= S_EXEC;
        end
        S_EXEC: if (is_mem) state <= S_MEM;
          else if (op == 4'hC) state <= S_HALT;
          else begin
            pc <= pc_next;
            state <= S_FETCH;
          end
        S_MEM: if (dmem_ack) begin
          pc <= pc_inc;
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  // register file write port; r0 and indices beyond REG_COUNT drop writes
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) for (int i = 0; i < 16; i++) regs[i] <= '0;
    else if (wb_en && ir[11:8] != 4'd0 && int'(ir[11:8]) < REG_COUNT) regs[ir[11:8]] <= wb_val;
endmodule

// File: tb/tb_mps_multicycle_core.sv
// tb_mps_multicycle_core: directed table-driven bench with wait-state memory models
module tb_mps_multicycle_core;
`ifdef MPS_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  logic clock, nreset;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retired, halted;
  logic [7:0] imem_addr, dmem_addr;
  logic [15:0] imem_value, dmem_wvalue, dmem_rvalue;
  logic i8_req, d8_req, d8_we, r8, h8;
  logic [7:0] i8_addr, d8_addr;
  logic [15:0] d8_wv, s8;
  logic [15:0] imem [256];
  logic [15:0] dinit [256];
  logic [15:0] dram [256];
  int dtag [256];
  int gen, iwait, dwait, icnt, dcnt, checks, errors;
  typedef struct {
    string name;
    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] want;
  } vec_t;
  vec_t vecs [14];

  mps_multicycle_core dut (
    .clock(clock), .nreset(nreset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_value(imem_value),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wvalue(dmem_wvalue),
    .dmem_ack(dmem_ack), .dmem_rvalue(dmem_rvalue), .retired(retired), .halted(halted)
  );

  mps_multicycle_core #(.REG_COUNT(8)) u8 (
    .clock(clock), .nreset(nreset),
    .imem_req(i8_req), .imem_addr(i8_addr), .imem_ack(i8_req), .imem_value(imem[i8_addr]),
    .dmem_req(d8_req), .dmem_we(d8_we), .dmem_addr(d8_addr), .dmem_wvalue(d8_wv),
    .dmem_ack(d8_req), .dmem_rvalue(16'h0000), .retired(r8), .halted(h8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imem_value = imem[imem_addr];
  assign imem_ack = icnt >= iwait;
  assign dmem_ack = dcnt >= dwait;
  assign dmem_rvalue = (dtag[dmem_addr] == gen) ? dram[dmem_addr] : dinit[dmem_addr];

  always @(posedge clock) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      dram[dmem_addr] <= dmem_wvalue;
      dtag[dmem_addr] <= gen;
    end
    if (d8_req && d8_we) s8 <= d8_wv;
  end

  function automatic logic [15:0] drd(input int a);
    return (dtag[a] == gen) ? dram[a] : dinit[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic load(input logic [15:0] p[$], input logic [15:0] fill);
    gen++;
    for (int i = 0; i < 256; i++) begin
      imem[i] = fill;
      dinit[i] = 16'h0000;
    end
    for (int i = 0; i < p.size(); i++) imem[i] = p[i];
  endtask

  task automatic do_reset();
    @(negedge clock);
    nreset = 1'b0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic run_halt(input int budget);
    int c = 0;
    while (!halted && c < budget) begin
      @(negedge clock);
      c++;
    end
    chk("halt_reached", halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;
    iwait = 0;
    dwait = 0;
    gen = 1;
    checks = 0;
    errors = 0;
    vecs = '{
      '{"add",      4'h1, 4'd3, 8'h05, 8'h03, 16'h0008},
      '{"sub",      4'h2, 4'd3, 8'h03, 8'h05, 16'hFFFE},
      '{"and",      4'h3, 4'd3, 8'h0C, 8'h0A, 16'h0008},
      '{"or",       4'h4, 4'd3, 8'h0C, 8'h0A, 16'h000E},
      '{"xor",      4'h5, 4'd3, 8'h0C, 8'h0A, 16'h0006},
      '{"shl_mod",  4'h6, 4'd3, 8'h01, 8'h11, 16'h0002},
      '{"shr",      4'h7, 4'd3, 8'hFF, 8'h04, 16'h0FFF},
      '{"shr_neg",  4'h7, 4'd3, 8'h80, 8'h17, 16'h01FF},
      '{"add_wrap", 4'h1, 4'd3, 8'hFF, 8'hFF, 16'hFFFE},
      '{"li_neg",   4'h1, 4'd3, 8'hFF, 8'h00, 16'hFFFF},
      '{"li",       4'h8, 4'd3, 8'h00, 8'h00, 16'h0012},
      '{"r0_write", 4'h1, 4'd0, 8'h01, 8'h01, 16'h0000},
      '{"reserved", 4'hD, 4'd3, 8'h07, 8'h07, 16'h0000},
      '{"rd_eq_ra", 4'h1, 4'd1, 8'h05, 8'h03, 16'h0008}
    };
    load('{16'h8105, 16'h8203, 16'h1312, 16'hC000}, 16'hC000);
    repeat (3) @(negedge clock);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wvalue", dmem_wvalue, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    do_reset();
    for (int s = 1; s <= 12; s++) begin
      @(negedge clock);
      if (s == 1) chk("first_fetch_c2", imem_req, 1);
      if (s == 8) chk("halted_before", halted, 0);
      chk($sformatf("retired_c%0d", s + 1), retired, (s == 2 || s == 4 || s == 6 || s == 8));
    end
    chk("halted_sticky", halted, 1);
    foreach (vecs[k]) begin
      load('{{4'h8, 4'd1, vecs[k].a}, {4'h8, 4'd2, vecs[k].b}, {vecs[k].op, vecs[k].rd, 8'h12},
             {8'hA0, 4'd0, vecs[k].rd}, 16'hC000}, 16'hC000);
      do_reset();
      run_halt(60);
      chk(vecs[k].name, drd(0), vecs[k].want);
    end
    begin
      int r[$];
      logic pr;
      logic [7:0] pa;
      pr = 1'b0;
      pa = 8'h00;
      iwait = 3;
      load('{16'h81FF, 16'h8202, 16'hA001, 16'hC000}, 16'hC000);
      do_reset();
      for (int s = 1; s <= 40 && !halted; s++) begin
        @(negedge clock);
        if (imem_req && pr) chk("iaddr_stable", imem_addr, pa);
        pr = imem_req;
        pa = imem_addr;
        if (retired) r.push_back(s);
      end
      chk("ws_halt", halted, 1);
      chk("ws_retires", r.size(), 4);
      chk("ws_interval_li", r.size() >= 2 ? r[1] - r[0] : -1, 5);
      chk("ws_interval_st", r.size() >= 3 ? r[2] - r[1] : -1, 6);
      chk("ws_li_minus1", drd(0), 16'hFFFF);
      iwait = 0;
    end
    begin
      int run, first;
      run = 0;
      first = -1;
      dwait = 2;
      load('{16'h8110, 16'h8212, 16'h8308, 16'h6223, 16'h8434, 16'h4224,
             16'hA012, 16'h9410, 16'hA004, 16'hC000}, 16'hC000);
      do_reset();
      for (int s = 1; s <= 80 && !halted; s++) begin
        @(negedge clock);
        if (dmem_req && dmem_we && first < 0) begin
          chk("st_addr", dmem_addr, 8'h10);
          chk("st_wvalue", dmem_wvalue, 16'h1234);
        end
        if (dmem_req && dmem_we) run++;
        else if (run > 0 && first < 0) first = run;
      end
      chk("ldst_halt", halted, 1);
      chk("st_we_cycles", first, 3);
      chk("st_mem", drd(16), 16'h1234);
      chk("ld_r4", drd(0), 16'h1234);
      dwait = 0;
    end
    load('{16'h8101, 16'hB105, 16'hB002, 16'h8503, 16'h8604, 16'h8707,
           16'h1856, 16'h1887, 16'hA008, 16'hC000}, 16'hC000);
    do_reset();
    run_halt(60);
    chk("beqz_paths", drd(0), BR ? 16'd7 : 16'd14);
    begin
      int c = 0;
      load('{16'hB0FF}, 16'hC000);
      do_reset();
      while (!retired && c < 10) begin
        @(negedge clock);
        c++;
      end
      chk("beqz_retired", retired, 1);
      @(negedge clock);
      chk("beqz_fetch", imem_req, 1);
      chk("beqz_self_pc", imem_addr, BR ? 8'h00 : 8'h01);
      repeat (10) @(negedge clock);
      chk("beqz_loop_halted", halted, BR ? 0 : 1);
    end
    begin
      int c = 0;
      load('{16'h0000}, 16'h0000);
      do_reset();
      while (!(imem_req && imem_addr == 8'hFF) && c < 700) begin
        @(negedge clock);
        c++;
      end
      chk("wrap_reach_ff", imem_addr, 8'hFF);
      c = 0;
      while (!(imem_req && imem_addr != 8'hFF) && c < 8) begin
        @(negedge clock);
        c++;
      end
      chk("wrap_fetch", imem_req, 1);
      chk("wrap_pc", imem_addr, 8'h00);
    end
    load('{16'h8907, 16'hA009, 16'hC000}, 16'hC000);
    do_reset();
    run_halt(30);
    chk("r9_rc16", drd(0), 16'h0007);
    chk("u8_halt", h8, 1);
    chk("r9_rc8", s8, 16'h0000);
    begin
      int c = 0;
      dwait = 20;
      load('{16'h8105, 16'h9215, 16'hC000}, 16'hC000);
      do_reset();
      while (!dmem_req && c < 20) begin
        @(negedge clock);
        c++;
      end
      chk("ld_wait_req", dmem_req, 1);
      #2;
      nreset = 1'b0;
      #1;
      chk("mid_rst_dmem_req", dmem_req, 0);
      chk("mid_rst_dmem_we", dmem_we, 0);
      chk("mid_rst_imem_req", imem_req, 0);
      chk("mid_rst_retired", retired, 0);
      chk("mid_rst_halted", halted, 0);
      dwait = 0;
      load('{16'hA001, 16'hC000}, 16'hC000);
      dinit[0] = 16'hDEAD;
      do_reset();
      @(negedge clock);
      chk("post_rst_fetch", imem_req, 1);
      chk("post_rst_pc", imem_addr, 8'h00);
      run_halt(30);
      chk("post_rst_regs", drd(0), 16'h0000);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mps_multicycle_core.md
# mps_multicycle_core

Parametrised multi-cycle successor to the single-cycle MPS CPU core. It fetches, executes and retires one 16-bit instruction at a time through a small state machine. Instruction and data memory are reached over req/ack handshakes, so both memories may insert wait states. It sits between the instruction ROM and the data RAM/peripheral bus of the MPS system.

## Interface
Parameters:
- DATA_WIDTH, 16: register/ALU/data-bus width; legal 8..32.
- IADDR_WIDTH, 8: instruction address width; PC wraps modulo 2^IADDR_WIDTH.
- DADDR_WIDTH, 8: data address width; address is the low DADDR_WIDTH bits of the register value.
- REG_COUNT, 16: implemented registers, 2..16; r0 reads 0; indices >= REG_COUNT read 0 and ignore writes.

Ports:
- clock, in, 1: sole clock, rising edge.
- nreset, in, 1: asynchronous, active-low reset.
- imem_req, out, 1: instruction fetch request.
- imem_addr, out, IADDR_WIDTH: fetch address (= PC).
- imem_ack, in, 1: fetch complete; imem_value valid this cycle.
- imem_value, in, 16: instruction word.
- dmem_req, out, 1: data access request.
- dmem_we, out, 1: 1 = store, 0 = load; valid while dmem_req.
- dmem_addr, out, DADDR_WIDTH: data address.
- dmem_wvalue, out, DATA_WIDTH: store data.
- dmem_ack, in, 1: access complete; dmem_rvalue valid for loads.
- dmem_rvalue, in, DATA_WIDTH: load data.
- retired, out, 1: one-cycle pulse per completed instruction.
- halted, out, 1: core stopped on HALT.

## Operation
- Encoding: [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb, imm8 = [7:0].
- 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR. All are rd = ra op rb, modulo 2^DATA_WIDTH, carries discarded.
- 6 SHL, 7 SHR (logical): shift amount = low clog2(DATA_WIDTH) bits of rb.
- 8 LI: rd = sign-extended imm8. 9 LD: rd = mem[ra]. A ST: mem[ra] = rb.
- B BEQZ: if reg[rd field] == 0 then PC = PC + 1 + sext(imm8), else PC + 1. The sum is truncated to IADDR_WIDTH.
- C HALT. D–F reserved, executed as NOP.
- States: BOOT -> FETCH -> EXEC -> (MEM ->) FETCH; HALT is terminal.
  - BOOT: all requests low; go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=PC. The instruction register is latched on the edge where imem_ack=1, then go to EXEC.
  - EXEC: LD/ST go to MEM. HALT goes to HALT. Every other opcode writes rd (if applicable), updates PC and pulses retired, then goes to FETCH.
  - MEM: dmem_req=1; dmem_addr, dmem_we and dmem_wvalue are held stable. On the ack edge, LD writes rd. PC+1 and retired pulse, then go to FETCH.
  - HALT: halted=1, all requests low; exit only via reset. HALT itself pulses retired once, on the EXEC->HALT edge.
- Requests and request payloads are combinational from state and registers. The payload is stable for the whole request.
- ack while no request is ignored. Writes to r0 are discarded.

## Timing
- Reset values: imem_req=0, dmem_req=0, dmem_we=0, imem_addr=0, dmem_addr=0, dmem_wvalue=0, retired=0, halted=0. PC=0, all registers 0, state BOOT.
- First imem_req is in the 2nd cycle after nreset deasserts.
- Ack may be high in the first request cycle (zero wait). Each wait cycle adds one cycle.
- Zero-wait latency: ALU/LI/BEQZ/NOP take 2 cycles per instruction. LD/ST take 3 cycles.
- A register written by instruction N is visible to N+1; there are no hazards in a multi-cycle design.
- Reset asserted mid-request: requests drop immediately (asynchronously). A store in progress is abandoned, and the bus must tolerate this.
- PC at 2^IADDR_WIDTH-1 increments to 0. A branch target wraps modulo 2^IADDR_WIDTH.

## Configuration
- MPS_BRANCH_EN defined: BEQZ behaves as specified.
- MPS_BRANCH_EN undefined: opcode B executes as NOP (PC+1, retired pulses) and no branch adder is built.

## Test plan
- Reset then zero-wait memories running LI r1,5; LI r2,3; ADD r3,r1,r2; HALT -> r3=8. Retired pulses in cycles 3,5,7,9 after reset release; halted=1 and stays 1.
- 3-wait-state imem -> imem_addr is stable during the wait, and one instruction completes every 5 cycles. LI r1,-1 at DATA_WIDTH=16 -> r1=0xFFFF.
- ST to addr 0x10 with value 0x1234, then LD r4 from 0x10, with 2-wait dmem -> dmem_we=1 held for 3 cycles on the store, and r4=0x1234.
- BEQZ r0,-1 at PC=0 (MPS_BRANCH_EN) -> PC stays 0 forever. Without the macro -> PC becomes 1. PC=0xFF with +1 -> PC wraps to 0x00.
- ADD r0,r1,r1 -> r0 still reads 0. With REG_COUNT=8, LI r9,7 -> r9 reads 0. SHL by rb=17 at DATA_WIDTH=16 -> shift by 1.
- nreset pulsed low mid-LD wait -> dmem_req drops in the same cycle. After release: state BOOT, PC=0, registers 0, halted=0.
